// File: rtl/dtree_seq_eval.sv
// rtl/dtree_seq_eval.sv - table-driven sequential decision-tree classifier
module dtree_seq_eval #(
   parameter int NFEAT     = 16,
   parameter int FW        = 8,
   parameter int NNODES    = 32,
   parameter int CW        = 4,
   parameter int MAX_DEPTH = 15,
   parameter logic [CW-1:0] DEFAULT_CLASS = '0,
   parameter int NIW       = $clog2(NNODES),
   parameter int FIW       = $clog2(NFEAT)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [NIW-1:0]      cfg_addr,
   input  logic                cfg_leaf,
   input  logic [FIW-1:0]      cfg_feat,
   input  logic [FW-1:0]       cfg_thr,
   input  logic [NIW-1:0]      cfg_left,
   input  logic [NIW-1:0]      cfg_right,
   input  logic [CW-1:0]       cfg_class,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NFEAT*FW-1:0] in_feat,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CW-1:0]       out_class,
   output logic                out_err,
   output logic                busy
);

   localparam int DW = $clog2(MAX_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;

   logic               r_leaf  [NNODES];
   logic [FIW-1:0]     r_feat  [NNODES];
   logic [FW-1:0]      r_thr   [NNODES];
   logic [NIW-1:0]     r_left  [NNODES];
   logic [NIW-1:0]     r_right [NNODES];
   logic [CW-1:0]      r_class [NNODES];

   logic [NFEAT*FW-1:0] r_feats;
   logic [NIW-1:0]     r_ptr;
   logic [DW-1:0]      r_depth;
   logic [CW-1:0]      r_out_class;
   logic               r_out_err;

   logic               w_leaf;
   logic [FIW-1:0]     w_feat_idx;
   logic [FW-1:0]      w_fval;
   logic               w_bad_feat;
   logic               w_abort;
   logic [NIW-1:0]     w_child;

   // current node is read straight out of the register table
   assign w_leaf     = r_leaf[r_ptr];
   assign w_feat_idx = r_feat[r_ptr];
   assign w_fval     = r_feats[32'(w_feat_idx) * FW +: FW];
   assign w_child    = (w_fval <= r_thr[r_ptr]) ? r_left[r_ptr] : r_right[r_ptr];

   // an out-of-range feature index can only occur when NFEAT is not a power of two
   generate
      if (NFEAT == (1 << FIW)) begin : g_feat_full
         assign w_bad_feat = 1'b0;
      end else begin : g_feat_part
         assign w_bad_feat = (32'(w_feat_idx) >= NFEAT);
      end
   endgenerate

   assign w_abort   = !w_leaf && ((r_depth == DW'(MAX_DEPTH)) || w_bad_feat);

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign out_class = r_out_class;
   assign out_err   = r_out_err;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state: accept, walk until leaf or abort, hold result until taken
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)           w_next = S_WALK;
         S_WALK:  if (w_leaf || w_abort)  w_next = S_DONE;
         S_DONE:  if (out_ready)          w_next = S_IDLE;
         default:                         w_next = S_IDLE;
      endcase
   end

   // walk datapath: feature latch, node pointer, depth counter, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_feats     <= '0;
         r_ptr       <= '0;
         r_depth     <= '0;
         r_out_class <= '0;
         r_out_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_feats <= in_feat;
                  r_ptr   <= '0;
                  r_depth <= '0;
               end
            end
            S_WALK: begin
               if (w_leaf) begin
                  r_out_class <= r_class[r_ptr];
                  r_out_err   <= 1'b0;
               end else if (w_abort) begin
                  r_out_class <= DEFAULT_CLASS;
                  r_out_err   <= 1'b1;
               end else begin
                  r_ptr   <= w_child;
                  r_depth <= r_depth + DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // node table: writable only while idle so a walk always sees one table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NNODES; i++) begin
            r_leaf[i]  <= 1'b0;
            r_feat[i]  <= '0;
            r_thr[i]   <= '0;
            r_left[i]  <= '0;
            r_right[i] <= '0;
            r_class[i] <= '0;
         end
      end else if (cfg_we && (r_state == S_IDLE)) begin
         r_leaf[cfg_addr]  <= cfg_leaf;
         r_feat[cfg_addr]  <= cfg_feat;
         r_thr[cfg_addr]   <= cfg_thr;
         r_left[cfg_addr]  <= cfg_left;
         r_right[cfg_addr] <= cfg_right;
         r_class[cfg_addr] <= cfg_class;
      end
   end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// tb/tb_dtree_seq_eval.sv - self-checking bench for dtree_seq_eval
module tb_dtree_seq_eval;

   localparam int NFEAT = 16, FW = 8, NNODES = 32, CW = 4, MAX_DEPTH = 15;
   localparam int NIW = 5, FIW = 4;

   logic                clk, rst_n;
   logic                cfg_we, cfg_leaf;
   logic [NIW-1:0]      cfg_addr, cfg_left, cfg_right;
   logic [FIW-1:0]      cfg_feat;
   logic [FW-1:0]       cfg_thr;
   logic [CW-1:0]       cfg_class;
   logic                in_valid, in_ready, out_valid, out_ready, out_err, busy;
   logic [NFEAT*FW-1:0] in_feat;
   logic [CW-1:0]       out_class;

   dtree_seq_eval dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_leaf(cfg_leaf),
      .cfg_feat(cfg_feat), .cfg_thr(cfg_thr), .cfg_left(cfg_left), .cfg_right(cfg_right),
      .cfg_class(cfg_class), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs = 0, checks = 0;

   // reference node table
   int m_leaf[NNODES], m_feat[NNODES], m_thr[NNODES], m_left[NNODES], m_right[NNODES], m_class[NNODES];
   int last_cls, last_err, last_lat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NNODES; i++) begin
         m_leaf[i] = 0; m_feat[i] = 0; m_thr[i] = 0; m_left[i] = 0; m_right[i] = 0; m_class[i] = 0;
      end
   endtask

   task automatic model_write(input int a, input int lf, input int f, input int t,
                              input int l, input int r, input int c);
      m_leaf[a] = lf; m_feat[a] = f; m_thr[a] = t; m_left[a] = l; m_right[a] = r; m_class[a] = c;
   endtask

   // walk the reference tree: class, abort flag and cycles from accept to out_valid
   task automatic model_eval(input logic [NFEAT*FW-1:0] fv, output int cls, output int err, output int lat);
      int p;
      p = 0; cls = 0; err = 1; lat = MAX_DEPTH + 2;
      for (int d = 0; d <= MAX_DEPTH; d++) begin
         if (m_leaf[p] != 0) begin
            cls = m_class[p]; err = 0; lat = d + 2;
            return;
         end
         if (d == MAX_DEPTH || m_feat[p] >= NFEAT) begin
            cls = 0; err = 1; lat = MAX_DEPTH + 2;
            return;
         end
         p = (int'(fv[m_feat[p]*FW +: FW]) <= m_thr[p]) ? m_left[p] : m_right[p];
         p = p % NNODES;
      end
   endtask

   task automatic drive_cfg(input int a, input int lf, input int f, input int t,
                            input int l, input int r, input int c);
      cfg_addr = NIW'(a); cfg_leaf = lf[0]; cfg_feat = FIW'(f); cfg_thr = FW'(t);
      cfg_left = NIW'(l); cfg_right = NIW'(r); cfg_class = CW'(c);
   endtask

   // idle-time table write, mirrored into the reference table
   task automatic cfg_write(input int a, input int lf, input int f, input int t,
                            input int l, input int r, input int c);
      @(negedge clk);
      drive_cfg(a, lf, f, t, l, r, c);
      cfg_we = 1'b1;
      @(posedge clk);
      model_write(a, lf, f, t, l, r, c);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // one classification: wmode 0 = none, 1 = write during walk, 2 = write in accept cycle
   task automatic send(input logic [NFEAT*FW-1:0] fv, input int hold, input int wmode,
                       input int waddr, input int wcls);
      int n, ecls, eerr, elat;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      in_feat  = fv;
      in_valid = 1'b1;
      if (wmode == 2) begin
         drive_cfg(waddr, 1, 0, 0, 0, 0, wcls);
         cfg_we = 1'b1;
      end
      @(posedge clk);
      if (wmode == 2) model_write(waddr, 1, 0, 0, 0, 0, wcls);
      model_eval(fv, ecls, eerr, elat);
      n = 1;
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      if (wmode == 1) begin
         drive_cfg(waddr, 1, 0, 0, 0, 0, wcls);
         cfg_we = 1'b1;
      end
      while (out_valid !== 1'b1 && n < 60) begin
         chk("in_ready_walk", in_ready, 0);
         chk("busy_walk", busy, 1);
         @(posedge clk);
         n++;
         @(negedge clk);
         cfg_we = 1'b0;
      end
      chk("latency", n, elat);
      chk("out_class", out_class, ecls);
      chk("out_err", out_err, eerr);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_class", out_class, ecls);
         chk("hold_err", out_err, eerr);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("post_busy", busy, 0);
      last_cls = ecls; last_err = eerr; last_lat = elat;
   endtask

   function automatic logic [NFEAT*FW-1:0] one_feat(input int k, input int v);
      logic [NFEAT*FW-1:0] fv;
      fv = '0;
      fv[k*FW +: FW] = FW'(v);
      return fv;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [NFEAT*FW-1:0] fv;
      rst_n = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_feat = '0;
      drive_cfg(0, 0, 0, 0, 0, 0, 0);
      model_clear();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_class", out_class, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // cleared table: node0 loops on itself until the depth limit
      send('0, 0, 0, 0, 0);
      chk("pin_rst_err", last_err, 1);
      chk("pin_rst_cls", last_cls, 0);
      chk("pin_rst_lat", last_lat, 17);

      // three-node tree; hold the result for five cycles
      cfg_write(0, 0, 0, 15, 1, 2, 0);
      cfg_write(1, 1, 0, 0, 0, 0, 3);
      cfg_write(2, 1, 0, 0, 0, 0, 7);
      send(one_feat(0, 15), 5, 0, 0, 0);
      chk("pin_t1_cls", last_cls, 3);
      chk("pin_t1_lat", last_lat, 3);
      send(one_feat(0, 16), 0, 1, 2, 1);
      chk("pin_walkwr_cls", last_cls, 7);
      cfg_write(2, 1, 0, 0, 0, 0, 1);
      send(one_feat(0, 16), 0, 0, 0, 0);
      chk("pin_idlewr_cls", last_cls, 1);
      send(one_feat(0, 16), 1, 2, 2, 5);
      chk("pin_samecyc_cls", last_cls, 5);

      // five-level chain on features 2, 5, 9, 12, 15
      cfg_write(0, 0, 2, 0, 1, 6, 0);
      cfg_write(1, 0, 5, 0, 2, 6, 0);
      cfg_write(2, 0, 9, 0, 3, 6, 0);
      cfg_write(3, 0, 12, 0, 4, 6, 0);
      cfg_write(4, 0, 15, 0, 7, 5, 0);
      cfg_write(5, 1, 0, 0, 0, 0, 9);
      cfg_write(6, 1, 0, 0, 0, 0, 2);
      cfg_write(7, 1, 0, 0, 0, 0, 4);
      send(one_feat(15, 255), 0, 0, 0, 0);
      chk("pin_chain_cls", last_cls, 9);
      chk("pin_chain_lat", last_lat, 7);

      // random tables, vectors, backpressure and ignored walk-time writes
      for (int t = 0; t < 3; t++) begin
         for (int a = 0; a < NNODES; a++)
            cfg_write(a, ($urandom % 5) < 2, $urandom_range(0, 15), $urandom_range(0, 255),
                      $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15));
         for (int v = 0; v < 12; v++) begin
            for (int k = 0; k < NFEAT; k++) fv[k*FW +: FW] = FW'($urandom);
            send(fv, $urandom_range(0, 3), ($urandom % 4 == 0) ? 1 : 0,
                 $urandom_range(0, 31), $urandom_range(0, 15));
         end
      end

      // reset during the second walk cycle
      cfg_write(0, 0, 0, 15, 1, 2, 0);
      cfg_write(1, 1, 0, 0, 0, 0, 3);
      cfg_write(2, 1, 0, 0, 0, 0, 7);
      @(negedge clk);
      in_feat = one_feat(0, 16);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_err", out_err, 0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      send(one_feat(0, 16), 0, 0, 0, 0);
      chk("pin_cleared_err", last_err, 1);
      chk("pin_cleared_lat", last_lat, 17);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/dtree_seq_eval.md
Name: dtree_seq_eval

Overview:
- Sequential, table-driven decision-tree classifier for multi-feature inputs.
- Generalises the hard-wired single-feature comparator tree: node table is run-time loadable, and feature count, feature width, tree size and class width are parameters.
- Walks the tree one node per clock and returns a class code over valid/ready handshakes.
- Sits between the feature-quantisation stage and the class-output/voting logic.

Parameters:
- NFEAT, 16, number of input features
- FW, 8, feature and threshold width (unsigned)
- NNODES, 32, node table entries; NIW = clog2(NNODES)
- CW, 4, class code width
- MAX_DEPTH, 15, max internal nodes traversed before abort
- DEFAULT_CLASS, 0, class reported on abort; CW bits
- FIW, clog2(NFEAT), feature index width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  node table write strobe
- cfg_addr  in  NIW  node index written
- cfg_leaf  in  1  1 = leaf node
- cfg_feat  in  FIW  feature index compared at an internal node
- cfg_thr  in  FW  threshold
- cfg_left  in  NIW  child taken when feature <= threshold
- cfg_right  in  NIW  child taken when feature > threshold
- cfg_class  in  CW  leaf class
- in_valid  in  1  feature vector valid
- in_ready  out  1  block can accept a vector
- in_feat  in  NFEAT*FW  features; feature k is in_feat[k*FW +: FW]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_class  out  CW  class result
- out_err  out  1  1 = walk aborted, out_class = DEFAULT_CLASS
- busy  out  1  state != IDLE

Behaviour:
- Reset, async on rst_n low:
  - state = IDLE; in_ready = 1; out_valid = 0; out_class = 0; out_err = 0; busy = 0.
  - Node pointer and depth counter = 0.
  - All node table fields cleared to 0.
- FSM states: IDLE, WALK, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_feat, ptr = 0, depth = 0, go to WALK.
- WALK: each cycle, read node[ptr] combinationally from the register table.
  - Leaf: out_class = node class, out_err = 0, go to DONE.
  - Internal node with depth == MAX_DEPTH, or feature index >= NFEAT: out_class = DEFAULT_CLASS, out_err = 1, go to DONE.
  - Otherwise: ptr = (feat[idx] <= thr) ? left : right; depth += 1.
  - Comparison is unsigned, full FW bits.
- DONE:
  - out_valid = 1; out_class and out_err held stable.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - in_ready is 0 in WALK and DONE; no same-cycle re-accept. A new vector is accepted no earlier than the cycle after the output handshake.
- Latency: for a leaf at depth d (root = depth 0), out_valid rises d+2 cycles after the accept edge. Abort: out_valid rises MAX_DEPTH+2 cycles after the accept edge.
- Config writes:
  - Take effect only in IDLE: node[cfg_addr] is written at the clock edge.
  - cfg_we in WALK or DONE is ignored, so the table is stable for a whole walk.
  - cfg_we and an accepted input in the same IDLE cycle: the write lands first; the walk starting next cycle sees the new table.
- Child pointer >= NNODES wraps modulo 2^NIW; no check beyond the depth limit.
- Cycles and self-loops are terminated by the depth limit.
- Reset mid-walk or mid-DONE: immediate return to reset values; the in-flight result is lost; the table is cleared.

Test Plan:
- Load node0 {int, f0, thr 15, L1, R2}, node1 {leaf, class 3}, node2 {leaf, class 7}. Send f0 = 15 -> out_class 3, out_err 0, out_valid 3 cycles after accept. Send f0 = 16 -> class 7.
- Five-level chain using features 2, 5, 9, 12, 15 with threshold 0; all features 0 except f15 = 255 -> reaches the right leaf at depth 5 (class 9), out_valid 7 cycles after accept.
- Table left at reset (node0 self-loop) -> out_err 1, out_class 0, out_valid MAX_DEPTH+2 = 17 cycles after accept.
- Hold out_ready = 0 for 5 cycles in DONE -> out_valid, out_class and out_err stable, in_ready 0. Then out_ready = 1 -> IDLE, next vector accepted the following cycle.
- During WALK, cfg_we rewrites node2 to class 1 -> ignored; result 7. The same write done in IDLE -> the next walk returns 1.
- Assert rst_n low on the 2nd cycle of WALK -> out_valid 0, in_ready 1 immediately; the table reads all-zero afterwards.
